ext_bus_arbiter: RTL and testbench
==================================

// Module: ext_bus_arbiter
// PURPOSE
//   Shares the core's single external bus (ext_valid/ext_ready handshake, 32-bit address/data, 4-bit write strobe, instruction flag) between two requesters.
//   Port 0 is instruction fetch and is read-only; port 1 is load/store data.
//   Round-robin arbitration; one transaction outstanding at a time.
//   Registered ext-side outputs and a bus-timeout watchdog that returns an error response when ext_ready never arrives.
// PARAMETERS
//   ADDR_W         32   address width
//   DATA_W         32   data width; strobe width = DATA_W/8
//   TIMEOUT_CYCLES 255  BUSY cycles without ext_ready before error; 0 disables the watchdog
// PORTS
//   clk              in   1       single clock, all logic rising-edge
//   reset_n          in   1       synchronous, active-low reset
//   if_valid         in   1       fetch request; held with if_address until if_ready
//   if_address       in   ADDR_W  fetch address
//   if_ready         out  1       one-cycle completion pulse for fetch
//   if_read_data     out  DATA_W  fetch data, valid while if_ready=1
//   if_error         out  1       fetch timed out, valid while if_ready=1
//   d_valid          in   1       data request; payload held until d_ready
//   d_address        in   ADDR_W  data address
//   d_write_data     in   DATA_W  store data
//   d_write_strobe   in   DATA_W/8  byte enables; all zero means read
//   d_ready          out  1       one-cycle completion pulse for data
//   d_read_data      out  DATA_W  load data, valid while d_ready=1
//   d_error          out  1       data access timed out, valid while d_ready=1
//   ext_valid        out  1       external request valid (registered)
//   ext_instruction  out  1       1 = current transaction is a fetch (port 0)
//   ext_address      out  ADDR_W  latched address
//   ext_write_data   out  DATA_W  latched store data
//   ext_write_strobe out  DATA_W/8  latched strobe; forced 0 for port 0
//   ext_ready        in   1       external completion; sampled only in BUSY
//   ext_read_data    in   DATA_W  external read data, sampled with ext_ready
//   busy             out  1       state != IDLE
// BEHAVIOUR
//   Reset (reset_n=0 at edge):
//     - state=IDLE; all outputs 0; last_grant=1 (fetch wins the first tie).
//   FSM states: IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: if any *_valid, grant the requester.
//     - On a tie, grant the port not granted last time.
//     - Latch its payload into ext_* and set ext_valid=1, state=BUSY, watchdog cleared.
//     - ext_valid therefore rises one cycle after *_valid is first sampled.
//   BUSY: ext_valid stays 1 and ext_* stay stable.
//     - ext_ready=1: capture ext_read_data, ext_valid<=0, err<=0, state=RESP.
//     - Else if TIMEOUT_CYCLES!=0 and the watchdog reaches TIMEOUT_CYCLES: ext_valid<=0, read data<=0, err<=1, state=RESP.
//     - ext_ready and timeout in the same cycle: ext_ready wins (no error).
//   RESP: the granted port's *_ready=1 for exactly one cycle, with *_read_data/*_error.
//     - Update last_grant; go to IDLE.
//     - The other port's ready stays 0.
//   Requesters may drop or change *_valid only after their *_ready.
//     - The IDLE after RESP samples a fresh request.
//   Minimum transaction: 3 cycles (IDLE sample, BUSY with immediate ext_ready, RESP).
//   ext_ready outside BUSY is ignored.
//   Watchdog counter saturates and never wraps.
//   Read data on the non-granted port holds its last value; it is meaningful only with ready.
//   Reset mid-transaction: the transaction is abandoned.
//     - ext_valid=0 and no ready pulse is issued on the next edge.
//   Port-0 fetch ignores strobe; ext_write_strobe=0 and ext_instruction=1.
// STRUCTURE
//   ext_bus_pkg:
//     - state enum (IDLE/BUSY/RESP)
//     - PORT_IF=0 / PORT_D=1 constants
//     - strobe-width function DATA_W/8
//   Sub-module ext_bus_watchdog: clear/enable/TIMEOUT_CYCLES -> expired; saturating counter.
//   The top level holds the FSM, round-robin flag and payload/response registers.
// TESTING
//   1. Fetch @0x0000_0100, ext_ready 2 cycles after ext_valid, data 0xDEADBEEF
//      -> ext_instruction=1, strobe=0, if_ready pulse with 0xDEADBEEF, if_error=0.
//   2. Store d_address=0x2000_0004, data=0x1234_5678, strobe=4'b0011, ext_ready immediate
//      -> ext_* match, d_ready 1 cycle after ext_ready, 3-cycle total.
//   3. if_valid and d_valid held continuously
//      -> grants alternate IF, D, IF, D; first grant after reset is IF.
//   4. TIMEOUT_CYCLES=4, ext_ready never asserted
//      -> ext_valid high 4 cycles then drops; d_ready=1, d_error=1, d_read_data=0.
//   5. reset_n=0 during BUSY
//      -> next cycle ext_valid=0, busy=0, no *_ready; a subsequent request completes normally.
//   6. ext_ready pulsed in IDLE and again in RESP
//      -> ignored, no spurious ready; ext_ready coincident with timeout -> no error.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the two-port external bus arbiter.
package ext_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ext_bus_watchdog.sv
// Saturating bus-timeout counter; expired is asserted during the BUSY cycle that
// would be the TIMEOUT_CYCLES-th one without a response. TIMEOUT_CYCLES=0 disables it.
module ext_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST  = LIMIT - ONE;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_q >= LAST);

endmodule

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter sharing one external bus between fetch (port 0) and
// load/store (port 1), one transaction at a time, with a timeout error path.
module ext_bus_arbiter
    import ext_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        if_valid,
    input  logic [ADDR_W-1:0]           if_address,
    output logic                        if_ready,
    output logic [DATA_W-1:0]           if_read_data,
    output logic                        if_error,
    input  logic                        d_valid,
    input  logic [ADDR_W-1:0]           d_address,
    input  logic [DATA_W-1:0]           d_write_data,
    input  logic [strb_w(DATA_W)-1:0]   d_write_strobe,
    output logic                        d_ready,
    output logic [DATA_W-1:0]           d_read_data,
    output logic                        d_error,
    output logic                        ext_valid,
    output logic                        ext_instruction,
    output logic [ADDR_W-1:0]           ext_address,
    output logic [DATA_W-1:0]           ext_write_data,
    output logic [strb_w(DATA_W)-1:0]   ext_write_strobe,
    input  logic                        ext_ready,
    input  logic [DATA_W-1:0]           ext_read_data,
    output logic                        busy
);

    localparam int STRB_W = strb_w(DATA_W);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                ext_valid_q, ext_valid_d;
    logic                ext_instruction_q, ext_instruction_d;
    logic [ADDR_W-1:0]   ext_address_q, ext_address_d;
    logic [DATA_W-1:0]   ext_write_data_q, ext_write_data_d;
    logic [STRB_W-1:0]   ext_write_strobe_q, ext_write_strobe_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_err_q, if_err_d;
    logic                d_err_q, d_err_d;
    logic                req_grant;
    logic                wd_expired;

    ext_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q == ST_IDLE),
        .enable  (state_q == ST_BUSY),
        .expired (wd_expired)
    );

    // A tie goes to the port that did not win last time.
    always_comb begin
        if (if_valid && d_valid) begin
            req_grant = ~last_grant_q;
        end else if (d_valid) begin
            req_grant = PORT_D;
        end else begin
            req_grant = PORT_IF;
        end
    end

    always_comb begin
        state_d            = state_q;
        last_grant_d       = last_grant_q;
        grant_d            = grant_q;
        ext_valid_d        = ext_valid_q;
        ext_instruction_d  = ext_instruction_q;
        ext_address_d      = ext_address_q;
        ext_write_data_d   = ext_write_data_q;
        ext_write_strobe_d = ext_write_strobe_q;
        if_rdata_d         = if_rdata_q;
        d_rdata_d          = d_rdata_q;
        if_err_d           = if_err_q;
        d_err_d            = d_err_q;
        case (state_q)
            ST_IDLE: begin
                if (if_valid || d_valid) begin
                    grant_d            = req_grant;
                    ext_valid_d        = 1'b1;
                    ext_instruction_d  = (req_grant == PORT_IF);
                    ext_address_d      = (req_grant == PORT_D) ? d_address : if_address;
                    ext_write_data_d   = (req_grant == PORT_D) ? d_write_data : '0;
                    ext_write_strobe_d = (req_grant == PORT_D) ? d_write_strobe : '0;
                    state_d            = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real response beats a coincident timeout.
                if (ext_ready || wd_expired) begin
                    ext_valid_d = 1'b0;
                    state_d     = ST_RESP;
                    if (grant_q == PORT_D) begin
                        d_rdata_d = ext_ready ? ext_read_data : '0;
                        d_err_d   = !ext_ready;
                    end else begin
                        if_rdata_d = ext_ready ? ext_read_data : '0;
                        if_err_d   = !ext_ready;
                    end
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q            <= ST_IDLE;
            last_grant_q       <= PORT_D;
            grant_q            <= PORT_IF;
            ext_valid_q        <= 1'b0;
            ext_instruction_q  <= 1'b0;
            ext_address_q      <= '0;
            ext_write_data_q   <= '0;
            ext_write_strobe_q <= '0;
            if_rdata_q         <= '0;
            d_rdata_q          <= '0;
            if_err_q           <= 1'b0;
            d_err_q            <= 1'b0;
        end else begin
            state_q            <= state_d;
            last_grant_q       <= last_grant_d;
            grant_q            <= grant_d;
            ext_valid_q        <= ext_valid_d;
            ext_instruction_q  <= ext_instruction_d;
            ext_address_q      <= ext_address_d;
            ext_write_data_q   <= ext_write_data_d;
            ext_write_strobe_q <= ext_write_strobe_d;
            if_rdata_q         <= if_rdata_d;
            d_rdata_q          <= d_rdata_d;
            if_err_q           <= if_err_d;
            d_err_q            <= d_err_d;
        end
    end

    assign if_ready         = (state_q == ST_RESP) && (grant_q == PORT_IF);
    assign d_ready          = (state_q == ST_RESP) && (grant_q == PORT_D);
    assign if_read_data     = if_rdata_q;
    assign d_read_data      = d_rdata_q;
    assign if_error         = if_err_q;
    assign d_error          = d_err_q;
    assign ext_valid        = ext_valid_q;
    assign ext_instruction  = ext_instruction_q;
    assign ext_address      = ext_address_q;
    assign ext_write_data   = ext_write_data_q;
    assign ext_write_strobe = ext_write_strobe_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter with a 4-cycle bus timeout.
module tb_ext_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic [31:0] if_address;
    logic        if_ready;
    logic [31:0] if_read_data;
    logic        if_error;
    logic        d_valid;
    logic [31:0] d_address;
    logic [31:0] d_write_data;
    logic [3:0]  d_write_strobe;
    logic        d_ready;
    logic [31:0] d_read_data;
    logic        d_error;
    logic        ext_valid;
    logic        ext_instruction;
    logic [31:0] ext_address;
    logic [31:0] ext_write_data;
    logic [3:0]  ext_write_strobe;
    logic        ext_ready;
    logic [31:0] ext_read_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    ext_bus_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_valid         (if_valid),
        .if_address       (if_address),
        .if_ready         (if_ready),
        .if_read_data     (if_read_data),
        .if_error         (if_error),
        .d_valid          (d_valid),
        .d_address        (d_address),
        .d_write_data     (d_write_data),
        .d_write_strobe   (d_write_strobe),
        .d_ready          (d_ready),
        .d_read_data      (d_read_data),
        .d_error          (d_error),
        .ext_valid        (ext_valid),
        .ext_instruction  (ext_instruction),
        .ext_address      (ext_address),
        .ext_write_data   (ext_write_data),
        .ext_write_strobe (ext_write_strobe),
        .ext_ready        (ext_ready),
        .ext_read_data    (ext_read_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-24s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        logic [31:0] rr_data;
        reset_n = 1'b0; if_valid = 1'b0; if_address = '0; d_valid = 1'b0;
        d_address = '0; d_write_data = '0; d_write_strobe = '0;
        ext_ready = 1'b0; ext_read_data = '0;
        step(); step();
        chk("rst_ext_valid", 32'(ext_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        reset_n = 1'b1;

        // 1: fetch, ext_ready two cycles after ext_valid
        if_valid = 1'b1; if_address = 32'h0000_0100;
        step();
        chk("t1_ext_valid", 32'(ext_valid), 32'd1);
        chk("t1_instr", 32'(ext_instruction), 32'd1);
        chk("t1_strobe", 32'(ext_write_strobe), 32'd0);
        chk("t1_addr", ext_address, 32'h0000_0100);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_valid_hold", 32'(ext_valid), 32'd1);
        chk("t1_no_ready_yet", 32'(if_ready), 32'd0);
        ext_ready = 1'b1; ext_read_data = 32'hDEAD_BEEF;
        step();
        chk("t1_if_ready", 32'(if_ready), 32'd1);
        chk("t1_if_data", if_read_data, 32'hDEAD_BEEF);
        chk("t1_if_error", 32'(if_error), 32'd0);
        chk("t1_d_ready", 32'(d_ready), 32'd0);
        chk("t1_ext_valid_drop", 32'(ext_valid), 32'd0);
        ext_ready = 1'b0; if_valid = 1'b0;
        step();
        chk("t1_if_ready_pulse", 32'(if_ready), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: store with immediate ext_ready
        d_valid = 1'b1; d_address = 32'h2000_0004; d_write_data = 32'h1234_5678;
        d_write_strobe = 4'b0011;
        step();
        chk("t2_instr", 32'(ext_instruction), 32'd0);
        chk("t2_addr", ext_address, 32'h2000_0004);
        chk("t2_wdata", ext_write_data, 32'h1234_5678);
        chk("t2_strobe", 32'(ext_write_strobe), 32'h3);
        ext_ready = 1'b1; ext_read_data = 32'hCAFE_F00D;
        step();
        chk("t2_d_ready", 32'(d_ready), 32'd1);
        chk("t2_d_error", 32'(d_error), 32'd0);
        chk("t2_if_ready", 32'(if_ready), 32'd0);
        chk("t2_if_data_hold", if_read_data, 32'hDEAD_BEEF);
        ext_ready = 1'b0; d_valid = 1'b0; d_write_strobe = 4'b0000;
        step();
        chk("t2_d_ready_pulse", 32'(d_ready), 32'd0);

        // 3: continuous contention after reset alternates IF, D, IF, D
        reset_n = 1'b0;
        step();
        chk("t3_rst_addr", ext_address, 32'd0);
        reset_n = 1'b1;
        if_valid = 1'b1; if_address = 32'h0000_0300;
        d_valid = 1'b1; d_address = 32'h0000_0400; d_write_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t3_instr_%0d", i), 32'(ext_instruction), 32'((i % 2) == 0));
            rr_data = 32'hA000_0000 + 32'(i);
            ext_ready = 1'b1; ext_read_data = rr_data;
            step();
            chk($sformatf("t3_if_ready_%0d", i), 32'(if_ready), 32'((i % 2) == 0));
            chk($sformatf("t3_d_ready_%0d", i), 32'(d_ready), 32'((i % 2) == 1));
            chk($sformatf("t3_data_%0d", i), ((i % 2) == 0) ? if_read_data : d_read_data, rr_data);
            ext_ready = 1'b0;
            step();
        end
        if_valid = 1'b0; d_valid = 1'b0;
        step();

        // 4: timeout on a data read
        d_valid = 1'b1; d_address = 32'h0000_5000; ext_read_data = 32'hFFFF_FFFF;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("t4_valid_%0d", i), 32'(ext_valid), 32'd1);
        end
        step();
        chk("t4_valid_drop", 32'(ext_valid), 32'd0);
        chk("t4_d_ready", 32'(d_ready), 32'd1);
        chk("t4_d_error", 32'(d_error), 32'd1);
        chk("t4_d_data", d_read_data, 32'd0);
        d_valid = 1'b0;
        step();

        // 5: reset in BUSY abandons the transaction
        if_valid = 1'b1; if_address = 32'h0000_0600;
        step();
        chk("t5_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        step();
        chk("t5_rst_valid", 32'(ext_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        reset_n = 1'b1;
        step();
        chk("t5_restart_addr", ext_address, 32'h0000_0600);
        ext_ready = 1'b1; ext_read_data = 32'h0000_600D;
        step();
        chk("t5_if_ready", 32'(if_ready), 32'd1);
        chk("t5_if_data", if_read_data, 32'h0000_600D);
        ext_ready = 1'b0; if_valid = 1'b0;
        step();

        // 6: ext_ready outside BUSY is ignored; ready beats coincident timeout
        ext_ready = 1'b1; ext_read_data = 32'h0000_0BAD;
        step();
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_idle_ready", {30'd0, if_ready, d_ready}, 32'd0);
        d_valid = 1'b1; d_address = 32'h0000_0700; ext_read_data = 32'h0000_0077;
        step();
        chk("t6_sample_no_ready", 32'(d_ready), 32'd0);
        step();
        chk("t6_d_ready", 32'(d_ready), 32'd1);
        chk("t6_d_data", d_read_data, 32'h0000_0077);
        d_valid = 1'b0;
        step();
        chk("t6_resp_ignored", {30'd0, if_ready, d_ready}, 32'd0);
        step();
        chk("t6_idle_again", {29'd0, busy, if_ready, d_ready}, 32'd0);
        ext_ready = 1'b0;
        if_valid = 1'b1; if_address = 32'h0000_0800;
        step(); step(); step(); step();
        chk("t6_still_busy", 32'(ext_valid), 32'd1);
        ext_ready = 1'b1; ext_read_data = 32'h0000_A5A5;
        step();
        chk("t6_tie_ready", 32'(if_ready), 32'd1);
        chk("t6_tie_error", 32'(if_error), 32'd0);
        chk("t6_tie_data", if_read_data, 32'h0000_A5A5);
        ext_ready = 1'b0; if_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
